multdiv_sequencer: RTL and testbench

- Execute-stage controller for the multi-cycle HI/LO operations that the decode stage flags with ctl.is_multdiv and ctl.multicycle_type (M_MULT, M_MULTU, M_DIV, M_DIVU).
- Accepts one request, holds the pipeline with a stall request and sequences either a fixed-latency multiply or a 32-iteration radix-2 divide.
- Presents the HI/LO result for exactly one retire window.
- Handles flushes by killing the in-flight operation.

---
 rtl/decode_pkg.sv | 25 ++
 rtl/multdiv_sequencer_div_core.sv | 64 ++++++
 rtl/multdiv_sequencer.sv | 169 ++++++++++++++++
 tb/tb_multdiv_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Decode-stage shared types: multi-cycle HI/LO operation codes and the
// multdiv sequencer state encoding.
package decode_pkg;

    typedef enum logic [1:0] {
        M_MULT  = 2'd0,
        M_MULTU = 2'd1,
        M_DIV   = 2'd2,
        M_DIVU  = 2'd3
    } multicycle_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } mdseq_state_t;

    localparam int DIV_ITERS = 32;

    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/multdiv_sequencer_div_core.sv
// Unsigned 32-bit restoring divider, one quotient bit per step enable.
module div_core (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        step_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [32:0] shifted_s;
    logic        fits_s;
    logic [31:0] rem_step_s;
    logic [31:0] quo_step_s;

    // Trial subtraction; the low 32 bits of the difference are exact whenever it fits.
    always_comb begin
        shifted_s  = {rem_q, quo_q[31]};
        fits_s     = (shifted_s >= {1'b0, dvs_q});
        rem_step_s = fits_s ? (shifted_s[31:0] - dvs_q) : shifted_s[31:0];
        quo_step_s = {quo_q[30:0], fits_s};
    end

    // Outputs include the step being taken this cycle, so the controller can
    // capture the final result on the same edge as the last iteration.
    assign quotient_o  = quo_step_s;
    assign remainder_o = rem_step_s;

    // Next-state selection: load, iterate or hold.
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        if (start_i) begin
            rem_d = 32'd0;
            quo_d = dividend_i;
            dvs_d = divisor_i;
        end else if (step_i) begin
            rem_d = rem_step_s;
            quo_d = quo_step_s;
        end else begin
            rem_d = rem_q;
        end
    end

    // Divider datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q <= 32'd0;
            quo_q <= 32'd0;
            dvs_q <= 32'd0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

endmodule

// File: rtl/multdiv_sequencer.sv
// Execute-stage controller for multi-cycle MULT/MULTU/DIV/DIVU: stalls the
// pipeline, sequences the operation and presents HI/LO for one retire window.
module multdiv_sequencer
    import decode_pkg::*;
#(
    parameter int MULT_LAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    input  multicycle_t type_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [5:0] MUL_LAST = 6'(MULT_LAT - 1);
    localparam logic [5:0] DIV_LAST = 6'(DIV_ITERS - 1);

    mdseq_state_t state_q, state_d;
    multicycle_t  type_q, type_d;
    logic [5:0]   count_q, count_d;
    logic         sa_q, sa_d;
    logic         sb_q, sb_d;
    logic [31:0]  a_q, a_d;
    logic [31:0]  b_q, b_d;
    logic [31:0]  hi_q, hi_d;
    logic [31:0]  lo_q, lo_d;

    logic         div_start_s;
    logic         div_step_s;
    logic [31:0]  div_quo_s;
    logic [31:0]  div_rem_s;
    logic         mul_sx_s;
    logic [63:0]  prod_s;
    logic         is_div_s;
    logic         is_signed_s;

    assign mul_sx_s = (type_q == M_MULT);
    assign prod_s   = {{32{mul_sx_s & a_q[31]}}, a_q} * {{32{mul_sx_s & b_q[31]}}, b_q};

    assign is_div_s    = (type_i == M_DIV) || (type_i == M_DIVU);
    assign is_signed_s = (type_i == M_MULT) || (type_i == M_DIV);

    div_core u_div_core (
        .clk         (clk),
        .reset       (reset),
        .start_i     (div_start_s),
        .step_i      (div_step_s),
        .dividend_i  (a_d),
        .divisor_i   (b_d),
        .quotient_o  (div_quo_s),
        .remainder_o (div_rem_s)
    );

    // Next-state and datapath capture; flush overrides everything, including
    // a completion that would otherwise land this cycle.
    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        count_d     = count_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        a_d         = a_q;
        b_d         = b_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        div_start_s = 1'b0;
        div_step_s  = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        type_d  = type_i;
                        count_d = 6'd0;
                        sa_d    = is_signed_s & a_i[31];
                        sb_d    = is_signed_s & b_i[31];
                        if (is_div_s) begin
                            a_d = cond_neg32(a_i, is_signed_s & a_i[31]);
                            b_d = cond_neg32(b_i, is_signed_s & b_i[31]);
                            if (b_i == 32'd0) begin
                                hi_d    = a_i;
                                lo_d    = 32'hFFFF_FFFF;
                                state_d = DONE;
                            end else begin
                                div_start_s = 1'b1;
                                state_d     = DIV;
                            end
                        end else begin
                            a_d     = a_i;
                            b_d     = b_i;
                            state_d = MUL;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                MUL: begin
                    count_d = count_q + 6'd1;
                    if (count_q == MUL_LAST) begin
                        hi_d    = prod_s[63:32];
                        lo_d    = prod_s[31:0];
                        state_d = DONE;
                    end else begin
                        state_d = MUL;
                    end
                end
                DIV: begin
                    div_step_s = 1'b1;
                    count_d    = count_q + 6'd1;
                    if (count_q == DIV_LAST) begin
                        hi_d    = cond_neg32(div_rem_s, sa_q);
                        lo_d    = cond_neg32(div_quo_s, sa_q ^ sb_q);
                        state_d = DONE;
                    end else begin
                        state_d = DIV;
                    end
                end
                DONE: begin
                    if (stall_i) begin
                        state_d = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Controller and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            type_q  <= M_MULT;
            count_q <= 6'd0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            count_q <= count_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy_o = ((state_q == IDLE) && valid_i && !flush_i) ||
                    (state_q == MUL) || (state_q == DIV);
    assign done_o = (state_q == DONE);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench for multdiv_sequencer: directed operations push expected
// HI/LO pairs; a monitor pops and compares on each rising done_o.
module tb_multdiv_sequencer;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i;
    multicycle_t type_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        stall_i;
    logic        flush_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;
    logic        done_prev = 1'b0;

    multdiv_sequencer #(.MULT_LAT(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .valid_i (valid_i),
        .type_i  (type_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .stall_i (stall_i),
        .flush_i (flush_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: each new done window must match the oldest expected result.
    always @(negedge clk) begin
        if (reset) begin
            done_prev = 1'b0;
        end else begin
            if (done_o && !done_prev) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got hi=%h lo=%h expected no completion", hi_o, lo_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("result_hi", {32'd0, hi_o}, {32'd0, mon_e[63:32]});
                    check("result_lo", {32'd0, lo_o}, {32'd0, mon_e[31:0]});
                end
            end
            done_prev = done_o;
        end
    end

    task automatic run_op(input string name, input multicycle_t t, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int lat,
                          input int stall_n);
        int k;
        int busy_cnt;
        bit seen;
        @(negedge clk);
        valid_i = 1'b1;
        type_i  = t;
        a_i     = a;
        b_i     = b;
        exp_q.push_back(exp);
        #1;
        busy_cnt = busy_o ? 1 : 0;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        type_i  = M_DIVU;
        a_i     = ~a;
        b_i     = 32'd0;
        k    = 1;
        seen = 1'b0;
        while (!seen && k <= 100) begin
            if (done_o) begin
                seen = 1'b1;
            end else begin
                if (busy_o) busy_cnt++;
                @(posedge clk);
                #1;
                k++;
            end
        end
        check({name, "_latency"}, 64'(k), 64'(lat));
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(lat));
        check({name, "_busy_in_done"}, {63'd0, busy_o}, 64'd0);
        if (stall_n > 0) begin
            stall_i = 1'b1;
            valid_i = 1'b1;
            type_i  = M_DIVU;
            a_i     = 32'd9;
            b_i     = 32'd0;
            for (int i = 0; i < stall_n; i++) begin
                @(posedge clk);
                #1;
                check({name, "_stall_done"}, {63'd0, done_o}, 64'd1);
                check({name, "_stall_busy"}, {63'd0, busy_o}, 64'd0);
            end
            stall_i = 1'b0;
            valid_i = 1'b0;
        end
        @(posedge clk);
        #1;
        check({name, "_done_drop"}, {63'd0, done_o}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b1;
        valid_i = 1'b0;
        type_i  = M_MULT;
        a_i     = 32'd0;
        b_i     = 32'd0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {hi_o, lo_o}, 64'd0);
        check("reset_flags", {62'd0, busy_o, done_o}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("mult_neg", M_MULT, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 4, 0);
        run_op("multu_max", M_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 4, 0);
        run_op("mult_negneg", M_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFF9, 64'h0000_0000_0000_0023, 4, 0);
        run_op("div_neg", M_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0);
        run_op("div_negdivisor", M_DIV, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33, 0);
        run_op("divu", M_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 33, 0);
        run_op("div_overflow", M_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33, 0);
        run_op("divu_by_zero", M_DIVU, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, 1, 0);

        // Flush a divide in its tenth iteration cycle.
        @(negedge clk);
        valid_i = 1'b1;
        type_i  = M_DIV;
        a_i     = 32'd1000;
        b_i     = 32'd3;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        check("flush_idle", {62'd0, busy_o, done_o}, 64'd0);
        check("flush_keeps_result", {hi_o, lo_o}, 64'h0000_0005_FFFF_FFFF);
        run_op("mult_after_flush", M_MULT, 32'd6, 32'd7, 64'h0000_0000_0000_002A, 4, 0);

        // Accept coinciding with flush is dropped.
        @(negedge clk);
        valid_i = 1'b1;
        type_i  = M_MULTU;
        a_i     = 32'd2;
        b_i     = 32'd2;
        flush_i = 1'b1;
        #1;
        check("flush_accept_busy", {63'd0, busy_o}, 64'd0);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("flush_accept_dropped", {62'd0, busy_o, done_o}, 64'd0);

        run_op("multu_stall", M_MULTU, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 4, 3);
        run_op("divu_b2b", M_DIVU, 32'd1000, 32'd10, 64'h0000_0000_0000_0064, 33, 0);
        run_op("multu_b2b", M_MULTU, 32'd3, 32'd5, 64'h0000_0000_0000_000F, 4, 0);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        valid_i = 1'b1;
        type_i  = M_DIV;
        a_i     = 32'd77;
        b_i     = 32'd5;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_result", {hi_o, lo_o}, 64'd0);
        check("async_reset_flags", {62'd0, busy_o, done_o}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("mult_after_reset", M_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 4, 0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
